sdft_scanner: RTL and testbench



---
 rtl/sdft_scanner.sv | 149 ++++++++++++++
 tb/tb_sdft_scanner.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdft_scanner.sv
// sdft_scanner: sample forwarder and bin read-out sequencer for the sdft core.
// Arbitrates start/read pulses and streams approximate bin magnitudes downstream.
module sdft_scanner #(
    parameter int  data_width = 8,
    parameter int  freq_bins  = 16,
    parameter int  freq_w     = data_width*2+4,
    localparam int AW         = $clog2(freq_bins)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic signed [data_width-1:0] sample_in,
    input  logic                         sample_valid,
    input  logic                         scan_req,
    input  logic                         sdft_ready,
    input  logic signed [freq_w-1:0]     sdft_bin_real,
    input  logic signed [freq_w-1:0]     sdft_bin_imag,
    output logic                         sdft_start,
    output logic                         sdft_read,
    output logic [data_width-1:0]        sdft_sample,
    output logic [AW-1:0]                sdft_bin_addr,
    output logic                         mag_valid,
    input  logic                         mag_ready,
    output logic [freq_w:0]              mag_data,
    output logic [AW-1:0]                mag_bin,
    output logic                         mag_last,
    output logic                         scan_busy,
    output logic                         sample_drop
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_RD1, S_RD2, S_CAP, S_MAG, S_OUT
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_pend;
    logic [data_width-1:0] r_pend_sample;
    logic [AW-1:0]         r_bin;
    logic [freq_w-1:0]     r_abs_re, r_abs_im;

    logic                  w_can_issue, w_start, w_read, w_pend_nxt, w_last_bin;
    logic [data_width-1:0] w_start_val;
    logic [freq_w-1:0]     w_re_u, w_im_u, w_abs_re, w_abs_im, w_max, w_min;
    logic [freq_w:0]       w_mag;

    always_comb begin
        w_can_issue = sdft_ready && !sdft_start && !sdft_read;
        // A strobe arriving on the issue edge is treated as already pending,
        // so it is forwarded at once and takes precedence over a bin read.
        w_start     = w_can_issue && (r_pend || sample_valid);
        w_start_val = r_pend ? r_pend_sample : sample_in;
        w_read      = w_can_issue && !r_pend && !sample_valid && (r_state == S_ISSUE);
        w_pend_nxt  = w_start ? (r_pend && sample_valid) : (r_pend || sample_valid);
        w_last_bin  = (r_bin == AW'(freq_bins-1));
    end

    // Unsigned negation keeps -2^(freq_w-1) as +2^(freq_w-1) without wrapping.
    always_comb begin
        w_re_u   = sdft_bin_real;
        w_im_u   = sdft_bin_imag;
        w_abs_re = w_re_u[freq_w-1] ? -w_re_u : w_re_u;
        w_abs_im = w_im_u[freq_w-1] ? -w_im_u : w_im_u;
        if (r_abs_re >= r_abs_im) begin
            w_max = r_abs_re;
            w_min = r_abs_im;
        end else begin
            w_max = r_abs_im;
            w_min = r_abs_re;
        end
        w_mag = {1'b0, w_max} + {2'b00, w_min[freq_w-1:1]};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (scan_req) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_read) w_state_nxt = S_RD1;
            S_RD1:   w_state_nxt = S_RD2;
            S_RD2:   w_state_nxt = S_CAP;
            S_CAP:   w_state_nxt = S_MAG;
            S_MAG:   w_state_nxt = S_OUT;
            S_OUT:   if (mag_valid && mag_ready) w_state_nxt = mag_last ? S_IDLE : S_ISSUE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_pend        <= 1'b0;
            r_pend_sample <= '0;
            r_bin         <= '0;
            r_abs_re      <= '0;
            r_abs_im      <= '0;
            sdft_start    <= 1'b0;
            sdft_read     <= 1'b0;
            sdft_sample   <= '0;
            sdft_bin_addr <= '0;
            mag_valid     <= 1'b0;
            mag_data      <= '0;
            mag_bin       <= '0;
            mag_last      <= 1'b0;
            scan_busy     <= 1'b0;
            sample_drop   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            sdft_start <= w_start;
            sdft_read  <= w_read;
            r_pend     <= w_pend_nxt;
            if (sample_valid)
                r_pend_sample <= sample_in;
            if (sample_valid && r_pend && !w_start)
                sample_drop <= 1'b1;
            if (w_start)
                sdft_sample <= w_start_val;
            if (w_read)
                sdft_bin_addr <= r_bin;

            case (r_state)
                S_IDLE: begin
                    if (scan_req) begin
                        r_bin     <= '0;
                        scan_busy <= 1'b1;
                    end
                end
                S_CAP: begin
                    r_abs_re <= w_abs_re;
                    r_abs_im <= w_abs_im;
                end
                S_MAG: begin
                    mag_data  <= w_mag;
                    mag_bin   <= r_bin;
                    mag_last  <= w_last_bin;
                    mag_valid <= 1'b1;
                end
                S_OUT: begin
                    if (mag_valid && mag_ready) begin
                        mag_valid <= 1'b0;
                        if (mag_last)
                            scan_busy <= 1'b0;
                        else
                            r_bin <= r_bin + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdft_scanner.sv
// Self-checking bench for sdft_scanner with a behavioural sdft core stand-in
// and a scoreboard that predicts every magnitude word from the bin table.
module tb_sdft_scanner;

    localparam int DW = 8;
    localparam int NB = 16;
    localparam int FW = DW*2+4;
    localparam int AW = $clog2(NB);

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic signed [DW-1:0] sample_in = '0;
    logic                 sample_valid = 1'b0;
    logic                 scan_req = 1'b0;
    logic                 sdft_ready;
    logic signed [FW-1:0] bin_re = '0, bin_im = '0;
    logic                 sdft_start, sdft_read;
    logic [DW-1:0]        sdft_sample;
    logic [AW-1:0]        sdft_bin_addr;
    logic                 mag_valid;
    logic                 mag_ready = 1'b1;
    logic [FW:0]          mag_data;
    logic [AW-1:0]        mag_bin;
    logic                 mag_last, scan_busy, sample_drop;

    int n_cmp = 0, n_mis = 0;
    int n_words = 0, n_reads = 0, n_starts = 0, n_pulses = 0;
    int cyc = 0, rd_cyc = 0, exp_idx = 0;
    logic last_acc = 1'b0, prev_mv = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_samp = '0;
    logic [DW-1:0] exp_samp[$];
    longint mem_re[NB], mem_im[NB], got_mag[NB];

    // core stand-in
    int            core_busy = 0;
    logic          core_hold = 1'b0;
    logic          rd_pend = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    always #5 clk = ~clk;

    sdft_scanner #(.data_width(DW), .freq_bins(NB), .freq_w(FW)) dut (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .scan_req(scan_req), .sdft_ready(sdft_ready), .sdft_bin_real(bin_re),
        .sdft_bin_imag(bin_im), .sdft_start(sdft_start), .sdft_read(sdft_read),
        .sdft_sample(sdft_sample), .sdft_bin_addr(sdft_bin_addr), .mag_valid(mag_valid),
        .mag_ready(mag_ready), .mag_data(mag_data), .mag_bin(mag_bin), .mag_last(mag_last),
        .scan_busy(scan_busy), .sample_drop(sample_drop)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_mag(input int i);
        longint a, b;
        a = (mem_re[i] < 0) ? -mem_re[i] : mem_re[i];
        b = (mem_im[i] < 0) ? -mem_im[i] : mem_im[i];
        return (a >= b) ? a + b/2 : b + a/2;
    endfunction

    function automatic longint rnd_comp();
        logic [FW-1:0] r;
        r = FW'($urandom);
        return longint'($signed(r));
    endfunction

    function automatic logic [63:0] outs_vec();
        return 64'({sdft_start, sdft_read, sdft_sample, sdft_bin_addr, mag_valid,
                    mag_data, mag_bin, mag_last, scan_busy, sample_drop});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound, input string tag);
        for (int i = 0; i < bound && scan_busy; i++) tick();
        chk(tag, 64'(scan_busy), 64'd0);
    endtask

    // Core: busy for a few cycles after a start or read; bins appear two edges after a read.
    assign sdft_ready = (core_busy == 0) && !core_hold;
    always @(posedge clk) begin
        if (core_busy != 0) core_busy <= core_busy - 1;
        if (rd_pend) begin
            bin_re  <= FW'(mem_re[rd_addr]);
            bin_im  <= FW'(mem_im[rd_addr]);
            rd_pend <= 1'b0;
        end
        if (sdft_start) core_busy <= 3;
        if (sdft_read) begin
            core_busy <= 2;
            rd_addr   <= sdft_bin_addr;
            rd_pend   <= 1'b1;
        end
    end

    // Protocol monitor and magnitude scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            exp_idx   = 0;
            last_acc  = 1'b0;
            prev_mv   = 1'b0;
            prev_addr = sdft_bin_addr;
            prev_samp = sdft_sample;
        end else begin
            if (last_acc) begin
                chk("busy_fall", 64'(scan_busy), 64'd0);
                last_acc = 1'b0;
            end
            if (sdft_start || sdft_read) begin
                n_pulses++;
                chk("pulse_excl", 64'(sdft_start && sdft_read), 64'd0);
            end
            if (sdft_bin_addr != prev_addr) chk("addr_chg_w_read", 64'(sdft_read), 64'd1);
            if (sdft_sample != prev_samp) chk("samp_chg_w_start", 64'(sdft_start), 64'd1);
            if (sdft_start) begin
                n_starts++;
                chk("start_expected", 64'(exp_samp.size() != 0), 64'd1);
                if (exp_samp.size() != 0)
                    chk("start_sample", 64'(sdft_sample), 64'(exp_samp.pop_front()));
            end
            if (sdft_read) begin
                n_reads++;
                rd_cyc = cyc;
                chk("rd_addr", 64'(sdft_bin_addr), 64'(exp_idx));
            end
            if (mag_valid && !prev_mv) chk("rd_to_valid", 64'(cyc - rd_cyc), 64'd4);
            if (mag_valid && mag_ready) begin
                chk("mag_bin", 64'(mag_bin), 64'(exp_idx));
                chk("mag_last", 64'(mag_last), 64'(exp_idx == NB-1));
                chk("mag_data", 64'(mag_data), 64'(ref_mag(exp_idx)));
                chk("busy_hold", 64'(scan_busy), 64'd1);
                got_mag[exp_idx] = longint'(mag_data);
                n_words++;
                last_acc = (exp_idx == NB-1);
                exp_idx  = (exp_idx + 1) % NB;
            end
            prev_mv   = mag_valid;
            prev_addr = sdft_bin_addr;
            prev_samp = sdft_sample;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt, w0, r0, p0, s0, g, gap;
        logic found;

        for (int i = 0; i < NB; i++) begin
            mem_re[i]  = rnd_comp();
            mem_im[i]  = rnd_comp();
            got_mag[i] = -1;
        end
        mem_re[3] = -100;     mem_im[3] = 40;
        mem_re[9] = -524288;  mem_im[9] = 0;

        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_outs", outs_vec(), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        chk("rst_idle_busy", 64'(scan_busy), 64'd0);
        chk("rst_idle_drop", 64'(sample_drop), 64'd0);

        // full scan, no competing samples, mag_ready high
        w0 = n_words;
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 300 && scan_busy; i++) begin
            @(negedge clk);
            if (scan_busy) cnt++;
        end
        chk("scan_cycles", 64'(cnt), 64'd96);
        chk("scan_words", 64'(n_words - w0), 64'd16);
        chk("bin3_mag", 64'(got_mag[3]), 64'd120);
        chk("bin9_mag", 64'(got_mag[9]), 64'd524288);
        tick();

        // backpressure on bin 7
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mag_valid && mag_bin == AW'(7)) found = 1'b1;
            else tick();
        end
        mag_ready = 1'b0;
        chk("bp_found", 64'(found), 64'd1);
        r0 = n_reads;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 64'(mag_valid), 64'd1);
            chk("bp_bin", 64'(mag_bin), 64'd7);
            chk("bp_data", 64'(mag_data), 64'(ref_mag(7)));
        end
        chk("bp_no_read", 64'(n_reads - r0), 64'd0);
        mag_ready = 1'b1;
        wait_idle(200, "bp_idle");
        tick();

        // arbitration: sample strobe on the edge ISSUE becomes eligible
        core_hold = 1'b1;
        scan_req  = 1'b1;
        tick();
        scan_req = 1'b0;
        tick();
        tick();
        core_hold    = 1'b0;
        sample_valid = 1'b1;
        sample_in    = 8'h55;
        exp_samp.push_back(8'h55);
        tick();
        sample_valid = 1'b0;
        chk("arb_start", 64'(sdft_start), 64'd1);
        chk("arb_read", 64'(sdft_read), 64'd0);
        chk("arb_sample", 64'(sdft_sample), 64'h55);
        g = 0;
        while (!sdft_read && g < 20) begin
            tick();
            g++;
        end
        chk("arb_read_gap", 64'(g), 64'd5);
        wait_idle(200, "arb_idle");
        tick();

        // randomized scans with spaced samples, random backpressure, ignored scan_req
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < NB; i++) begin
                mem_re[i] = rnd_comp();
                mem_im[i] = rnd_comp();
            end
            if (s == 1) mem_im[2] = -524288;
            if (s == 2) begin mem_re[0] = -524288; mem_im[0] = -524288; end
            w0 = n_words;
            scan_req = 1'b1;
            tick();
            scan_req = 1'b0;
            gap = 0;
            for (int i = 0; i < 3000 && scan_busy; i++) begin
                mag_ready = ($urandom_range(0, 9) < 7);
                gap++;
                if (gap >= 8 && $urandom_range(0, 3) == 0) begin
                    sample_valid = 1'b1;
                    sample_in    = DW'($urandom);
                    exp_samp.push_back(sample_in);
                    gap = 0;
                end else begin
                    sample_valid = 1'b0;
                end
                scan_req = ($urandom_range(0, 30) == 0);
                tick();
            end
            sample_valid = 1'b0;
            scan_req     = 1'b0;
            mag_ready    = 1'b1;
            chk("rnd_idle", 64'(scan_busy), 64'd0);
            repeat (12) tick();
            chk("rnd_words", 64'(n_words - w0), 64'd16);
            chk("rnd_q_empty", 64'(exp_samp.size()), 64'd0);
            chk("rnd_no_drop", 64'(sample_drop), 64'd0);
        end

        // reset asserted while bin 5 waits in OUT
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mag_valid && mag_bin == AW'(5)) found = 1'b1;
            else tick();
        end
        mag_ready = 1'b0;
        chk("rst5_found", 64'(found), 64'd1);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_outs", outs_vec(), 64'd0);
        core_hold = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        p0 = n_pulses;
        sample_valid = 1'b1;
        sample_in    = 8'h5A;
        exp_samp.push_back(8'h5A);
        tick();
        sample_valid = 1'b0;
        scan_req     = 1'b1;
        tick();
        scan_req  = 1'b0;
        mag_ready = 1'b1;
        repeat (8) tick();
        chk("rst_no_pulse", 64'(n_pulses - p0), 64'd0);
        chk("rst_scan_busy", 64'(scan_busy), 64'd1);
        core_hold = 1'b0;
        w0 = n_words;
        wait_idle(300, "rst_scan_idle");
        chk("rst_scan_words", 64'(n_words - w0), 64'd16);
        tick();

        // overrun while the core is busy
        chk("pre_ov_drop", 64'(sample_drop), 64'd0);
        core_hold    = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 8'h11;
        tick();
        sample_in = 8'h22;
        tick();
        sample_valid = 1'b0;
        exp_samp.push_back(8'h22);
        tick();
        chk("ov_drop", 64'(sample_drop), 64'd1);
        s0 = n_starts;
        core_hold = 1'b0;
        for (int i = 0; i < 20 && n_starts == s0; i++) tick();
        chk("ov_start", 64'(n_starts - s0), 64'd1);
        chk("ov_sample", 64'(sdft_sample), 64'h22);
        repeat (4) tick();
        chk("ov_drop_sticky", 64'(sample_drop), 64'd1);
        chk("final_q_empty", 64'(exp_samp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
